thermocouple_sensor_emu: RTL and testbench

SPI responder that emulates a cold-junction-compensated thermocouple converter. It is used in bench and loopback builds to drive the SPI master that feeds the thermocouple reader. It runs periodic "conversions" that snapshot the temperature and fault inputs, then serializes a 32-bit read-only frame on MISO while the master holds chip-select low. The frame layout matches what the reader unpacks: tc[31:18], fault[16], junction[15:4], fault bits[2:0].

---
 rtl/thermocouple_sensor_emu_if.sv | 21 ++
 rtl/thermocouple_sensor_emu.sv | 170 +++++++++++++++++
 tb/tb_thermocouple_sensor_emu.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/thermocouple_sensor_emu_if.sv
// rtl/thermocouple_sensor_emu_if.sv - SPI bundle between the thermocouple emulator and its master
interface thermocouple_sensor_emu_if;
    logic sclk;
    logic cs_n;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk,
        output cs_n,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk,
        input  cs_n,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/thermocouple_sensor_emu.sv
// rtl/thermocouple_sensor_emu.sv - SPI responder emulating a cold-junction-compensated thermocouple converter
module thermocouple_sensor_emu #(
    parameter int CONV_CYCLES = 2400,
    parameter int CNT_BITS    = 17
) (
    input  logic                            clk,
    input  logic                            rst,
    thermocouple_sensor_emu_if.slave        spi,
    input  logic [13:0]                     tc_temp_in,
    input  logic [11:0]                     junction_temp_in,
    input  logic [2:0]                      fault_in,
    output logic                            frame_done,
    output logic                            short_frame,
    output logic                            overrun
);

    typedef enum logic [1:0] {
        ST_CONVERT = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CONV_CYCLES - 1);
    localparam logic [5:0]          BITS_FULL = 6'd32;
    localparam logic [5:0]          BITS_SAT  = 6'd33;

    // Synchronizer and history flops for the asynchronous SPI pins
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic sclk_s1_q, sclk_s2_q, sclk_h_q;

    state_t              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [13:0]         snap_tc_q;
    logic [11:0]         snap_junc_q;
    logic [2:0]          snap_fault_q;
    logic [31:0]         shift_q;
    logic [5:0]          bit_cnt_q;
    logic                oe_q;
    logic                done_q;
    logic                short_q;
    logic                overrun_q;
    logic                pend_q;

    logic                cs_fall;
    logic                cs_rise;
    logic                sclk_fall;
    logic [31:0]         frame_word;
    logic [CNT_BITS-1:0] cnt_d;
    logic [31:0]         shift_d;
    logic [5:0]          bit_cnt_d;

    // Two-flop synchronizers plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_h_q  <= 1'b0;
        end else begin
            cs_s1_q   <= spi.cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            sclk_s1_q <= spi.sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
        end
    end

    assign cs_fall   =  cs_h_q   & ~cs_s2_q;
    assign cs_rise   = ~cs_h_q   &  cs_s2_q;
    assign sclk_fall =  sclk_h_q & ~sclk_s2_q;

    // Frame assembly from the snapshot and next-state arithmetic
    always_comb begin
        frame_word = {snap_tc_q, 1'b0, |snap_fault_q, snap_junc_q, 1'b0, snap_fault_q};
        cnt_d      = cnt_q + CNT_BITS'(1);
        shift_d    = {shift_q[30:0], 1'b0};
        bit_cnt_d  = (bit_cnt_q == BITS_SAT) ? bit_cnt_q : bit_cnt_q + 6'd1;
    end

    // Conversion / shift / done sequencer with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CONVERT;
            cnt_q        <= '0;
            snap_tc_q    <= '0;
            snap_junc_q  <= '0;
            snap_fault_q <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            oe_q         <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            overrun_q    <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_CONVERT: begin
                    done_q  <= 1'b0;
                    short_q <= 1'b0;
                    if (cs_fall || pend_q) begin
                        // Select aborts the running conversion; the old snapshot is served
                        state_q   <= ST_SHIFT;
                        cnt_q     <= '0;
                        shift_q   <= frame_word;
                        bit_cnt_q <= '0;
                        oe_q      <= 1'b1;
                        overrun_q <= 1'b0;
                        pend_q    <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q        <= '0;
                        snap_tc_q    <= tc_temp_in;
                        snap_junc_q  <= junction_temp_in;
                        snap_fault_q <= fault_in;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_SHIFT: begin
                    if (cs_rise) begin
                        // Deselect: release the pad and report how the frame ended
                        state_q <= ST_DONE;
                        oe_q    <= 1'b0;
                        shift_q <= '0;
                        done_q  <= (bit_cnt_q >= BITS_FULL);
                        short_q <= (bit_cnt_q <  BITS_FULL);
                    end else if (sclk_fall) begin
                        // Zero fill keeps miso low once all 32 bits are out
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q >= BITS_FULL) begin
                            overrun_q <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_CONVERT;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    short_q <= 1'b0;
                    // A select arriving now is served on the next clock from CONVERT
                    if (cs_fall) begin
                        pend_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_CONVERT;
                    cnt_q   <= '0;
                    oe_q    <= 1'b0;
                    shift_q <= '0;
                    done_q  <= 1'b0;
                    short_q <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign spi.miso    = shift_q[31];
    assign spi.miso_oe = oe_q;
    assign frame_done  = done_q;
    assign short_frame = short_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_thermocouple_sensor_emu.sv
// tb/tb_thermocouple_sensor_emu.sv - scoreboard bench for the thermocouple SPI responder
`timescale 1ns/1ps
module tb_thermocouple_sensor_emu;

    localparam int CONV = 600;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] tc;
    logic [11:0] junc;
    logic [2:0]  fault;
    logic        frame_done;
    logic        short_frame;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int sf_cnt   = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    thermocouple_sensor_emu_if spi_if();

    thermocouple_sensor_emu #(
        .CONV_CYCLES(CONV),
        .CNT_BITS   (17)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi_if),
        .tc_temp_in      (tc),
        .junction_temp_in(junc),
        .fault_in        (fault),
        .frame_done      (frame_done),
        .short_frame     (short_frame),
        .overrun         (overrun)
    );

    always @(negedge clk) begin
        if (frame_done)  fd_cnt++;
        if (short_frame) sf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frame_of(input logic [13:0] t, input logic [11:0] j, input logic [2:0] f);
        return {t, 1'b0, |f, j, 1'b0, f};
    endfunction

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master transaction: nbits clocks, first 32 bits into word, the rest into extra
    task automatic spi_read(input int nbits, output logic [31:0] word, output logic [7:0] extra,
                            output logic ov_start);
        word  = '0;
        extra = '0;
        spi_if.cs_n = 1'b0;
        clocks(HALF);
        ov_start = overrun;
        check("oe_in_frame", {31'd0, spi_if.miso_oe}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) word  = {word[30:0], spi_if.miso};
            else        extra = {extra[6:0], spi_if.miso};
            spi_if.sclk = 1'b1;
            clocks(HALF);
            spi_if.sclk = 1'b0;
            clocks(HALF);
        end
        spi_if.cs_n = 1'b1;
    endtask

    // Close out a frame: pad released within 3 clk, then exactly the expected pulses
    task automatic frame_end(input string tag, input int fd0, input int sf0, input int exp_fd, input int exp_sf);
        clocks(3);
        check({tag, "_oe_off"}, {31'd0, spi_if.miso_oe}, 32'd0);
        clocks(7);
        check({tag, "_frame_done"}, fd_cnt - fd0, exp_fd);
        check({tag, "_short_frame"}, sf_cnt - sf0, exp_sf);
    endtask

    // Full 32-bit read compared against the scoreboard head
    task automatic read_full(input string tag, input logic [31:0] exp);
        logic [31:0] w;
        logic [7:0]  x;
        logic        ov;
        int          fd0;
        int          sf0;
        fd0 = fd_cnt;
        sf0 = sf_cnt;
        exp_q.push_back(exp);
        spi_read(32, w, x, ov);
        check({tag, "_word"}, w, exp_q.pop_front());
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        frame_end(tag, fd0, sf0, 1, 0);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  x;
        logic        ov;
        logic [19:0] part;
        logic [13:0] rtc;
        logic [11:0] rjn;
        int          fd0;
        int          sf0;

        rst         = 1'b0;
        spi_if.cs_n = 1'b1;
        spi_if.sclk = 1'b0;
        tc          = 14'h0190;
        junc        = 12'h190;
        fault       = 3'b000;
        clocks(3);
        check("rst_miso",        {31'd0, spi_if.miso},    32'd0);
        check("rst_miso_oe",     {31'd0, spi_if.miso_oe}, 32'd0);
        check("rst_frame_done",  {31'd0, frame_done},     32'd0);
        check("rst_short_frame", {31'd0, short_frame},    32'd0);
        check("rst_overrun",     {31'd0, overrun},        32'd0);
        rst = 1'b1;

        // Read before the first conversion: empty snapshot
        clocks(10);
        read_full("early", 32'h0000_0000);
        read_full("snap_still0", 32'h0000_0000);
        clocks(CONV - 40);
        read_full("conv_not_early", 32'h0000_0000);
        clocks(CONV + 10);
        read_full("basic", 32'h0640_1900);

        // Fault patterns
        fault = 3'b001;
        clocks(CONV + 10);
        read_full("fault_oc", 32'h0641_1901);
        fault = 3'b100;
        clocks(CONV + 10);
        read_full("fault_vcc", 32'h0641_1904);

        rtc   = 14'($urandom);
        rjn   = 12'($urandom);
        tc    = rtc;
        junc  = rjn;
        fault = 3'b010;
        clocks(CONV + 10);
        read_full("random", frame_of(rtc, rjn, 3'b010));

        // Short frame
        tc    = 14'h0190;
        junc  = 12'h190;
        fault = 3'b000;
        clocks(CONV + 10);
        fd0 = fd_cnt;
        sf0 = sf_cnt;
        exp_q.push_back(32'h0640_1900);
        spi_read(16, w, x, ov);
        check("short_bits", {16'd0, w[15:0]}, {16'd0, exp_q.pop_front() >> 16});
        frame_end("short", fd0, sf0, 0, 1);

        // Overrun: 40 falls, trailing bits zero, sticky until next select
        clocks(20);
        fd0 = fd_cnt;
        sf0 = sf_cnt;
        exp_q.push_back(32'h0640_1900);
        spi_read(40, w, x, ov);
        check("ovr_word", w, exp_q.pop_front());
        check("ovr_extra", {24'd0, x}, 32'd0);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        frame_end("ovr", fd0, sf0, 1, 0);
        clocks(20);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        fd0 = fd_cnt;
        sf0 = sf_cnt;
        exp_q.push_back(32'h0640_1900);
        spi_read(32, w, x, ov);
        check("ovr_cleared", {31'd0, ov}, 32'd0);
        check("after_ovr_word", w, exp_q.pop_front());
        frame_end("after_ovr", fd0, sf0, 1, 0);

        // Reset mid-frame with an input change in flight
        clocks(CONV + 10);
        fd0  = fd_cnt;
        sf0  = sf_cnt;
        part = '0;
        exp_q.push_back(32'h0640_1900);
        spi_if.cs_n = 1'b0;
        clocks(HALF);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) tc = 14'h3FFC;
            part = {part[18:0], spi_if.miso};
            spi_if.sclk = 1'b1;
            clocks(HALF);
            if (i < 19) begin
                spi_if.sclk = 1'b0;
                clocks(HALF);
            end
        end
        check("midrst_bits", {12'd0, part}, {12'd0, exp_q.pop_front() >> 12});
        check("midrst_pre_miso", {31'd0, spi_if.miso}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_miso",    {31'd0, spi_if.miso},    32'd0);
        check("midrst_miso_oe", {31'd0, spi_if.miso_oe}, 32'd0);
        spi_if.sclk = 1'b0;
        spi_if.cs_n = 1'b1;
        clocks(10);
        rst = 1'b1;
        clocks(10);
        check("midrst_no_done",  fd_cnt - fd0, 0);
        check("midrst_no_short", sf_cnt - sf0, 0);
        clocks(CONV + 10);
        read_full("post_rst", frame_of(14'h3FFC, 12'h190, 3'b000));

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
